ps2_receptor_teclado: RTL
=========================

# ps2_receptor_teclado

PS/2 keyboard receiver for the clock-configuration datapath: it deserialises PS/2 frames from the keyboard, drops break and unmapped codes, translates make codes to a compact key code set, and buffers them in a 4-entry FIFO. The PicoBlaze reads this FIFO as input port 0x02 through the top-level `in_port` mux, one key per read.

## Interface

Parameters:
- `PUERTO_TECLADO`, 8'h02: `port_id` value that pops the FIFO on `read_strobe`.
- `CICLOS_TIMEOUT`, 100000: clk cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 100 MHz).
- `FILTRO_BITS`, 8: width of the ps2clk glitch filter shift register.

Ports:
- `clk`, in, 1: system clock (100 MHz).
- `reset`, in, 1: asynchronous, active-high reset.
- `ps2data`, in, 1: PS/2 data line, asynchronous.
- `ps2clk`, in, 1: PS/2 clock line, asynchronous.
- `port_id`, in, 8: PicoBlaze port address.
- `read_strobe`, in, 1: PicoBlaze read strobe.
- `ascii_code`, out, 8: FIFO head key code; 8'h00 when the FIFO is empty.
- `dato_disponible`, out, 1: FIFO not empty.
- `error_trama`, out, 1: one-cycle pulse on a parity, start or stop error, or on a timeout.
- `desborde`, out, 1: one-cycle pulse when a code is dropped because the FIFO is full.

## Operation

**Input conditioning**
- `ps2clk` and `ps2data` each pass through a 2-FF synchroniser.
- Synchronised `ps2clk` feeds a `FILTRO_BITS` shift register.
- Filtered clock goes to 0 when the register is all zeros and to 1 when it is all ones; otherwise it holds.
- A bit is sampled on the filtered clock's 1→0 transition.

**Frame FSM**
- States: INICIO → DATOS (8 bits, LSB first) → PARIDAD → PARADA → INICIO.
- INICIO accepts only a sampled 0. A sampled 1 is ignored and the FSM stays in INICIO.
- Frame is valid only if the 9 bits (data + parity) have odd parity and the stop bit is 1.
- An invalid frame pulses `error_trama` and is discarded.
- Timeout: a counter runs in any state other than INICIO and clears on every sampled edge. Reaching `CICLOS_TIMEOUT` forces INICIO and pulses `error_trama`.

**Decoder** (acts on each valid byte)
- E0: set flag `ext`.
- F0: set flag `brk`.
- Any other byte: if `brk` is set, discard it; otherwise translate it and, if mapped, push it. Then clear both `ext` and `brk`.
- Non-extended map:
  - 45,16,1E,26,25,2E,36,3D,3E,46 → '0'..'9' (8'h30..8'h39).
  - 1C → 'A', 2C → 'T', 2B → 'F', 33 → 'H'.
  - 5A → 8'h0D.
  - 76 → 8'h1B.
- Extended map: 75 → 8'h80 (up), 72 → 8'h81 (down), 6B → 8'h82 (left), 74 → 8'h83 (right).
- A mapped code that arrives with the wrong `ext` state is unmapped.
- Unmapped codes are dropped silently, with no error pulse.
- Typematic repeats are enqueued like new presses.

**FIFO**
- 4 entries, 2-bit read and write pointers, 3-bit occupancy count.
- Pop: `read_strobe` and `port_id == PUERTO_TECLADO`, while not empty. A pop on empty is ignored.
- Push while full drops the new code and pulses `desborde`.
- Simultaneous push and pop on a full FIFO: both succeed and the count is unchanged.
- Simultaneous push and pop on an empty FIFO: the push succeeds and the pop is ignored.

**Reset**
- Clears the FSM to INICIO, both flags, the FIFO pointers and count, and the timeout counter.
- Filter register resets to all ones (line idle high).
- Output reset values: `ascii_code` = 8'h00, `dato_disponible` = 0, `error_trama` = 0, `desborde` = 0.
- Reset mid-frame discards the partial frame.

## Timing

- Synchroniser delay is 2 cycles; the filter adds `FILTRO_BITS` cycles. An edge is detected 10 cycles after the pin transition at default parameters.
- Valid stop bit → push: 2 cycles (decode register, then FIFO write). `dato_disponible` rises on the cycle after the write.
- `ascii_code` is combinational from FIFO memory at the read pointer. It is valid while `dato_disponible` = 1.
- The top-level mux registers `ascii_code` while `port_id` is held.
- The pop advances the read pointer at the clock edge ending the `read_strobe` cycle.
- The new head is visible on the next cycle.
- `error_trama` and `desborde` are exactly 1 cycle wide.

## Test plan

- Frame for 8'h16 (bits 0,0110_1000,0,1), then F0 16 → `ascii_code` = 8'h31, `dato_disponible` = 1, and exactly one FIFO entry (the break is discarded).
- E0 75 then E0 F0 75 → a single entry 8'h80. Pop with `port_id` = 8'h02 and `read_strobe` → `ascii_code` = 8'h00, `dato_disponible` = 0.
- Frame for 8'h45 with the parity bit flipped → one `error_trama` pulse, FIFO still empty.
- Six make codes '1'..'6' with no reads → FIFO holds '1'..'4', `desborde` pulses twice. Four pops return 31,32,33,34 in order.
- Start bit plus 3 data bits, then idle 100000 cycles → `error_trama` pulse. A following full 8'h5A frame yields 8'h0D.
- Assert `reset` after 5 bits of a frame → all outputs 0, and the next complete 8'h1C frame yields 8'h41.

Source files
------------

// File: rtl/ps2_receptor_teclado.sv
// PS/2 keyboard receiver: synchronise and filter the line, deserialise frames,
// translate make codes to a compact key set and queue them for the PicoBlaze.
module ps2_receptor_teclado #(
    parameter logic [7:0] PUERTO_TECLADO = 8'h02,
    parameter int         CICLOS_TIMEOUT = 100000,
    parameter int         FILTRO_BITS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2data,
    input  logic       ps2clk,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    output logic [7:0] ascii_code,
    output logic       dato_disponible,
    output logic       error_trama,
    output logic       desborde
);
    localparam int TW = $clog2(CICLOS_TIMEOUT + 1);

    typedef enum logic [1:0] {INICIO, DATOS, PARIDAD, PARADA} estado_t;

    logic [1:0]             clk_sync, dat_sync;
    logic [FILTRO_BITS-1:0] filtro;
    logic                   clk_filt, flanco;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filtro   <= '1;
            clk_filt <= 1'b1;
            flanco   <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2clk};
            dat_sync <= {dat_sync[0], ps2data};
            filtro   <= {filtro[FILTRO_BITS-2:0], clk_sync[1]};
            flanco   <= 1'b0;
            if (filtro == '0 && clk_filt) begin
                clk_filt <= 1'b0;
                flanco   <= 1'b1;
            end else if (filtro == '1) begin
                clk_filt <= 1'b1;
            end
        end
    end

    // Frame FSM
    estado_t       estado, estado_n;
    logic [2:0]    nbit, nbit_n;
    logic [7:0]    dato, dato_n;
    logic          par, par_n;
    logic [TW-1:0] cnt_to;
    logic          timeout, trama_ok, trama_err;
    logic [7:0]    byte_q;
    logic          byte_vld;

    assign timeout = (estado != INICIO) && (cnt_to == TW'(CICLOS_TIMEOUT - 1));

    always_comb begin
        estado_n  = estado;
        nbit_n    = nbit;
        dato_n    = dato;
        par_n     = par;
        trama_ok  = 1'b0;
        trama_err = 1'b0;
        if (timeout) begin
            estado_n  = INICIO;
            trama_err = 1'b1;
        end else if (flanco) begin
            case (estado)
                INICIO: if (!dat_sync[1]) begin
                    estado_n = DATOS;
                    nbit_n   = 3'd0;
                end
                DATOS: begin
                    dato_n = {dat_sync[1], dato[7:1]};
                    nbit_n = nbit + 3'd1;
                    if (nbit == 3'd7) estado_n = PARIDAD;
                end
                PARIDAD: begin
                    par_n    = dat_sync[1];
                    estado_n = PARADA;
                end
                default: begin
                    estado_n = INICIO;
                    if (dat_sync[1] && ^{dato, par}) trama_ok  = 1'b1;
                    else                             trama_err = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado      <= INICIO;
            nbit        <= 3'd0;
            dato        <= 8'h00;
            par         <= 1'b0;
            cnt_to      <= '0;
            byte_q      <= 8'h00;
            byte_vld    <= 1'b0;
            error_trama <= 1'b0;
        end else begin
            estado      <= estado_n;
            nbit        <= nbit_n;
            dato        <= dato_n;
            par         <= par_n;
            cnt_to      <= (estado == INICIO || flanco || timeout) ? '0 : cnt_to + 1'b1;
            byte_q      <= dato;
            byte_vld    <= trama_ok;
            error_trama <= trama_err;
        end
    end

    // Decoder: bit 8 of the result flags a mapped code
    function automatic logic [8:0] traducir(input logic e, input logic [7:0] b);
        case ({e, b})
            9'h045: traducir = 9'h130;
            9'h016: traducir = 9'h131;
            9'h01E: traducir = 9'h132;
            9'h026: traducir = 9'h133;
            9'h025: traducir = 9'h134;
            9'h02E: traducir = 9'h135;
            9'h036: traducir = 9'h136;
            9'h03D: traducir = 9'h137;
            9'h03E: traducir = 9'h138;
            9'h046: traducir = 9'h139;
            9'h01C: traducir = 9'h141;
            9'h02C: traducir = 9'h154;
            9'h02B: traducir = 9'h146;
            9'h033: traducir = 9'h148;
            9'h05A: traducir = 9'h10D;
            9'h076: traducir = 9'h11B;
            9'h175: traducir = 9'h180;
            9'h172: traducir = 9'h181;
            9'h16B: traducir = 9'h182;
            9'h174: traducir = 9'h183;
            default: traducir = 9'h000;
        endcase
    endfunction

    logic       ext, brk;
    logic [8:0] trad;
    logic       push, pop, lleno, vacio;

    assign trad = traducir(ext, byte_q);
    assign push = byte_vld && byte_q != 8'hE0 && byte_q != 8'hF0 && !brk && trad[8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_vld) begin
            if (byte_q == 8'hE0)      ext <= 1'b1;
            else if (byte_q == 8'hF0) brk <= 1'b1;
            else begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    // FIFO
    logic [7:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] cuenta;
    logic       escribe;

    assign vacio   = (cuenta == 3'd0);
    assign lleno   = (cuenta == 3'd4);
    assign pop     = read_strobe && (port_id == PUERTO_TECLADO) && !vacio;
    assign escribe = push && (!lleno || pop);

    always_ff @(posedge clk) begin
        if (escribe) mem[wr_ptr] <= trad[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            cuenta   <= 3'd0;
            desborde <= 1'b0;
        end else begin
            desborde <= push && !escribe;
            if (escribe) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            if (escribe && !pop)      cuenta <= cuenta + 3'd1;
            else if (pop && !escribe) cuenta <= cuenta - 3'd1;
        end
    end

    assign dato_disponible = !vacio;
    assign ascii_code      = vacio ? 8'h00 : mem[rd_ptr];
endmodule
